// File: rtl/run_ctl_if.sv
// rtl/run_ctl_if.sv - run controller control/status bundle between host side and run_ctl
interface run_ctl_if #(
  parameter int CNT_W = 32,
  parameter int NSTOP = 4
);
  logic             start;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] trace_lo;
  logic [CNT_W-1:0] trace_hi;
  logic [NSTOP-1:0] stop_req;
  logic [NSTOP-1:0] stop_mask;
  logic             halt;
  logic             cpu_reset;
  logic             running;
  logic             done;
  logic [2:0]       status;
  logic [NSTOP-1:0] stop_src;
  logic [CNT_W-1:0] cycle_count;
  logic             trace_en;

  modport master (
    output start, limit, trace_lo, trace_hi, stop_req, stop_mask, halt,
    input  cpu_reset, running, done, status, stop_src, cycle_count, trace_en
  );

  modport slave (
    input  start, limit, trace_lo, trace_hi, stop_req, stop_mask, halt,
    output cpu_reset, running, done, status, stop_src, cycle_count, trace_en
  );
endinterface

// File: rtl/run_ctl.sv
// rtl/run_ctl.sv - CPU run controller: reset hold, cycle counting, stop status, trace window
module run_ctl #(
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 10,
  parameter int NSTOP    = 4
) (
  input  logic     clk,
  input  logic     reset,
  run_ctl_if.slave bus
);
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [2:0] ST_NONE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_STOP  = 3'd2;
  localparam logic [2:0] ST_LIMIT = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t           r_state,  w_state_nxt;
  logic [HOLD_W-1:0] r_hold,  w_hold_nxt;
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
  logic [CNT_W-1:0] r_limit,  w_limit_nxt;
  logic [CNT_W-1:0] r_lo,     w_lo_nxt;
  logic [CNT_W-1:0] r_hi,     w_hi_nxt;
  logic [2:0]       r_status, w_status_nxt;
  logic [NSTOP-1:0] r_src,    w_src_nxt;
  logic             r_cpu_reset, w_cpu_reset_nxt;
  logic             r_running,   w_running_nxt;
  logic             r_done,      w_done_nxt;
  logic             r_trace_en,  w_trace_en_nxt;

  logic [NSTOP-1:0] w_hit;
  logic [NSTOP-1:0] w_hit_low;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_hit     = bus.stop_req & bus.stop_mask;
  assign w_hit_low = w_hit & (~w_hit + NSTOP'(1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_limit     <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_status    <= ST_NONE;
      r_src       <= '0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_trace_en  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_cnt       <= w_cnt_nxt;
      r_limit     <= w_limit_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_status    <= w_status_nxt;
      r_src       <= w_src_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_running   <= w_running_nxt;
      r_done      <= w_done_nxt;
      r_trace_en  <= w_trace_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_cnt_nxt    = r_cnt;
    w_limit_nxt  = r_limit;
    w_lo_nxt     = r_lo;
    w_hi_nxt     = r_hi;
    w_status_nxt = r_status;
    w_src_nxt    = r_src;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt  = S_HOLD;
          w_hold_nxt   = HOLD_W'(RST_HOLD - 1);
          w_cnt_nxt    = '0;
          w_limit_nxt  = bus.limit;
          w_lo_nxt     = bus.trace_lo;
          w_hi_nxt     = bus.trace_hi;
          w_status_nxt = ST_NONE;
          w_src_nxt    = '0;
        end
      end
      S_HOLD: begin
        if (r_hold == '0) w_state_nxt = S_RUN;
        else              w_hold_nxt  = r_hold - HOLD_W'(1);
      end
      S_RUN: begin
        // Terminating cycle leaves the count untouched: it counts completed cycles.
        if (bus.halt) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_HALT;
        end else if (|w_hit) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_STOP;
          w_src_nxt    = w_hit_low;
        end else if ((r_limit != '0) && (w_cnt_inc == r_limit)) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = ST_LIMIT;
        end else if (!(&r_cnt)) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every port comes straight from a flop.
  always_comb begin
    w_cpu_reset_nxt = (w_state_nxt != S_RUN);
    w_running_nxt   = (w_state_nxt == S_RUN);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_trace_en_nxt  = w_running_nxt && (w_lo_nxt <= w_cnt_nxt) && (w_cnt_nxt <= w_hi_nxt);
  end

  assign bus.cpu_reset   = r_cpu_reset;
  assign bus.running     = r_running;
  assign bus.done        = r_done;
  assign bus.status      = r_status;
  assign bus.stop_src    = r_src;
  assign bus.cycle_count = r_cnt;
  assign bus.trace_en    = r_trace_en;
endmodule

// File: tb/tb_run_ctl.sv
// tb/tb_run_ctl.sv - directed self-checking bench for run_ctl
module tb_run_ctl;
  localparam int CNT_W    = 32;
  localparam int RST_HOLD = 10;
  localparam int NSTOP    = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  run_ctl_if #(.CNT_W(CNT_W), .NSTOP(NSTOP)) bus ();

  run_ctl #(.CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .NSTOP(NSTOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic start_run(input logic [CNT_W-1:0] lim, input logic [CNT_W-1:0] lo,
                           input logic [CNT_W-1:0] hi);
    bus.limit    = lim;
    bus.trace_lo = lo;
    bus.trace_hi = hi;
    pulse_start();
    for (int i = 0; i < 50 && !bus.running; i++) @(negedge clk);
    n_checks++;
    if (bus.running !== 1'b1) begin
      n_fails++;
      $display("FAIL run_entry: running=%b required 1 within 50 cycles", bus.running);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if (bus.cpu_reset !== 1'b1 || bus.running !== 1'b0 || bus.done !== 1'b0 ||
        bus.status !== 3'd0 || bus.stop_src !== '0 || bus.cycle_count !== '0 ||
        bus.trace_en !== 1'b0) begin
      n_fails++;
      $display("FAIL %s: cpu_reset=%b running=%b done=%b status=%0d stop_src=%b count=%0d trace_en=%b required 1 0 0 0 0000 0 0",
               tag, bus.cpu_reset, bus.running, bus.done, bus.status, bus.stop_src,
               bus.cycle_count, bus.trace_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_values");
    reset = 1'b1;
    @(negedge clk);
    // T1: async reset in the middle of HOLD
    bus.limit = 0;
    pulse_start();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("reset_mid_hold");
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (bus.running !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_stays_idle: running=%b cpu_reset=%b required 0 1", bus.running, bus.cpu_reset);
    end
  endtask

  task automatic test_hold_time();
    int n_hi;
    logic [CNT_W-1:0] c0;
    n_hi = 0;
    bus.limit = 0;
    pulse_start();
    for (int i = 0; i < 50 && bus.cpu_reset; i++) begin
      n_hi++;
      @(negedge clk);
    end
    n_checks++;
    if (n_hi !== RST_HOLD) begin
      n_fails++;
      $display("FAIL hold_length: cpu_reset high %0d cycles required %0d", n_hi, RST_HOLD);
    end
    n_checks++;
    if (bus.running !== 1'b1 || bus.cycle_count !== 0) begin
      n_fails++;
      $display("FAIL hold_to_run: running=%b count=%0d required 1 0", bus.running, bus.cycle_count);
    end
    repeat (3) @(negedge clk);
    c0 = bus.cycle_count;
    pulse_start();
    n_checks++;
    if (bus.running !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.cycle_count !== c0 + 1) begin
      n_fails++;
      $display("FAIL start_in_run: running=%b cpu_reset=%b count=%0d required 1 0 %0d",
               bus.running, bus.cpu_reset, bus.cycle_count, c0 + 1);
    end
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
  endtask

  task automatic test_limit();
    int n_run;
    n_run = 0;
    start_run(5, 0, 0);
    for (int i = 0; i < 50 && bus.running; i++) begin
      n_run++;
      @(negedge clk);
    end
    n_checks++;
    if (n_run !== 5) begin
      n_fails++;
      $display("FAIL limit_run_cycles: %0d required 5", n_run);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.status !== 3'd3 || bus.cycle_count !== 4 || bus.cpu_reset !== 1'b1) begin
      n_fails++;
      $display("FAIL limit_done: done=%b status=%0d count=%0d cpu_reset=%b required 1 3 4 1",
               bus.done, bus.status, bus.cycle_count, bus.cpu_reset);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || bus.status !== 3'd3 || bus.cycle_count !== 4) begin
      n_fails++;
      $display("FAIL limit_hold: done=%b status=%0d count=%0d required 1 3 4",
               bus.done, bus.status, bus.cycle_count);
    end
  endtask

  task automatic test_halt();
    start_run(0, 0, 0);
    repeat (7) @(negedge clk);
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1 || bus.status !== 3'd1 || bus.cycle_count !== 7 || bus.stop_src !== '0) begin
      n_fails++;
      $display("FAIL halt_stop: done=%b status=%0d count=%0d stop_src=%b required 1 1 7 0000",
               bus.done, bus.status, bus.cycle_count, bus.stop_src);
    end
  endtask

  task automatic test_stop_priority();
    start_run(3, 0, 0);
    repeat (2) @(negedge clk);
    bus.stop_req  = 4'b0110;
    bus.stop_mask = 4'b0100;
    @(negedge clk);
    bus.stop_req  = 4'b0000;
    n_checks++;
    if (bus.status !== 3'd2 || bus.stop_src !== 4'b0100 || bus.cycle_count !== 2) begin
      n_fails++;
      $display("FAIL stop_over_limit: status=%0d stop_src=%b count=%0d required 2 0100 2",
               bus.status, bus.stop_src, bus.cycle_count);
    end
    start_run(0, 0, 0);
    bus.stop_req  = 4'b1010;
    bus.stop_mask = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (bus.status !== 3'd2 || bus.stop_src !== 4'b0010 || bus.cycle_count !== 0) begin
      n_fails++;
      $display("FAIL stop_lowest_src: status=%0d stop_src=%b count=%0d required 2 0010 0",
               bus.status, bus.stop_src, bus.cycle_count);
    end
    start_run(0, 0, 0);
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt      = 1'b0;
    bus.stop_req  = 4'b0000;
    bus.stop_mask = 4'b0000;
    n_checks++;
    if (bus.status !== 3'd1 || bus.stop_src !== 4'b0000) begin
      n_fails++;
      $display("FAIL halt_over_stop: status=%0d stop_src=%b required 1 0000", bus.status, bus.stop_src);
    end
  endtask

  task automatic test_trace_window();
    logic exp_te;
    int   n_te;
    n_te = 0;
    start_run(6, 2, 3);
    for (int i = 0; i < 50 && bus.running; i++) begin
      exp_te = (bus.cycle_count >= 2) && (bus.cycle_count <= 3);
      n_checks++;
      if (bus.trace_en !== exp_te) begin
        n_fails++;
        $display("FAIL trace_window: count=%0d trace_en=%b required %b", bus.cycle_count, bus.trace_en, exp_te);
      end
      if (bus.trace_en === 1'b1) n_te++;
      @(negedge clk);
    end
    n_checks++;
    if (n_te !== 2 || bus.trace_en !== 1'b0 || bus.status !== 3'd3 || bus.cycle_count !== 5) begin
      n_fails++;
      $display("FAIL trace_done: window_cycles=%0d trace_en=%b status=%0d count=%0d required 2 0 3 5",
               n_te, bus.trace_en, bus.status, bus.cycle_count);
    end
  endtask

  task automatic test_back_to_back();
    int n_te;
    n_te = 0;
    bus.limit    = 6;
    bus.trace_lo = 4;
    bus.trace_hi = 1;
    pulse_start();
    n_checks++;
    if (bus.done !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.status !== 3'd0 || bus.cycle_count !== 0) begin
      n_fails++;
      $display("FAIL restart_from_done: done=%b cpu_reset=%b status=%0d count=%0d required 0 1 0 0",
               bus.done, bus.cpu_reset, bus.status, bus.cycle_count);
    end
    for (int i = 0; i < 50 && !bus.done; i++) begin
      if (bus.trace_en === 1'b1) n_te++;
      @(negedge clk);
    end
    n_checks++;
    if (n_te !== 0 || bus.done !== 1'b1 || bus.status !== 3'd3 || bus.cycle_count !== 5) begin
      n_fails++;
      $display("FAIL inverted_window: trace_cycles=%0d done=%b status=%0d count=%0d required 0 1 3 5",
               n_te, bus.done, bus.status, bus.cycle_count);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.limit     = '0;
    bus.trace_lo  = '0;
    bus.trace_hi  = '0;
    bus.stop_req  = '0;
    bus.stop_mask = '0;
    bus.halt      = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold_time();
    test_limit();
    test_halt();
    test_stop_priority();
    test_trace_window();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
